// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_access_ctrl: two-port arbiter and load/store/RMW sequencer for dmem |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module dmem_access_ctrl #(
  parameter int ADDR_W = 64,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic              m0_we,
  input  logic [1:0]        m0_size,
  input  logic              m0_unsigned,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [63:0]       m0_wdata,
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic              m1_we,
  input  logic [1:0]        m1_size,
  input  logic              m1_unsigned,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [63:0]       m1_wdata,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [63:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [63:0]       mem_write_data,
  input  logic [63:0]       mem_read_data
);

  typedef enum logic [2:0] {IDLE, LOAD, ST_RD, ST_WR, RESP} state_t;

  state_t              state;
  logic                last_grant;
  logic                lat_id;
  logic                lat_uns;
  logic [1:0]          lat_size;
  logic [2:0]          lat_off;
  logic [63:0]         lat_wdata;

  logic                grant;
  logic                accept;
  logic                sel_we;
  logic                sel_uns;
  logic                sel_misaligned;
  logic [1:0]          sel_size;
  logic [ADDR_W-1:0]   sel_addr;
  logic [63:0]         sel_wdata;

  function automatic logic [63:0] load_ext(input logic [63:0] dw, input logic [2:0] off,
                                           input logic [1:0] sz, input logic uns);
    logic [63:0] sh;
    sh = dw >> {off, 3'b000};
    case (sz)
      2'd0:    load_ext = uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}}, sh[7:0]};
      2'd1:    load_ext = uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd2:    load_ext = uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: load_ext = sh;
    endcase
  endfunction

  function automatic logic [63:0] st_merge(input logic [63:0] old, input logic [63:0] wd,
                                           input logic [2:0] off, input logic [1:0] sz);
    logic [7:0]  bm;
    logic [63:0] m;
    case (sz)
      2'd0:    bm = 8'h01;
      2'd1:    bm = 8'h03;
      2'd2:    bm = 8'h0F;
      default: bm = 8'hFF;
    endcase
    bm = bm << off;
    for (int i = 0; i < 8; i++) m[i*8 +: 8] = {8{bm[i]}};
    st_merge = (old & ~m) | ((wd << {off, 3'b000}) & m);
  endfunction

  always_comb begin
    grant = 1'b0;
    if (m0_valid && m1_valid) grant = RR_EN ? ~last_grant : 1'b0;
    else if (m1_valid)        grant = 1'b1;
    sel_we    = grant ? m1_we       : m0_we;
    sel_size  = grant ? m1_size     : m0_size;
    sel_uns   = grant ? m1_unsigned : m0_unsigned;
    sel_addr  = grant ? m1_addr     : m0_addr;
    sel_wdata = grant ? m1_wdata    : m0_wdata;
    case (sel_size)
      2'd0:    sel_misaligned = 1'b0;
      2'd1:    sel_misaligned = sel_addr[0];
      2'd2:    sel_misaligned = |sel_addr[1:0];
      default: sel_misaligned = |sel_addr[2:0];
    endcase
  end

  // ready is combinational, so it is gated by reset to keep every output low in reset
  assign accept   = (state == IDLE) && (m0_valid || m1_valid) && rst_n;
  assign m0_ready = accept && !grant;
  assign m1_ready = accept && grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      lat_id         <= 1'b0;
      lat_uns        <= 1'b0;
      lat_size       <= 2'd0;
      lat_off        <= 3'd0;
      lat_wdata      <= 64'd0;
      rsp_valid      <= 1'b0;
      rsp_id         <= 1'b0;
      rsp_rdata      <= 64'd0;
      rsp_err        <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= grant;
            lat_id     <= grant;
            lat_uns    <= sel_uns;
            lat_size   <= sel_size;
            lat_off    <= sel_addr[2:0];
            lat_wdata  <= sel_wdata;
            if (sel_misaligned) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_id    <= grant;
              rsp_rdata <= 64'd0;
              rsp_err   <= 1'b1;
            end else begin
              mem_address <= {sel_addr[ADDR_W-1:3], 3'b000};
              if (!sel_we) begin
                state    <= LOAD;
                mem_read <= 1'b1;
              end else if (sel_size == 2'd3) begin
                state          <= ST_WR;
                mem_write      <= 1'b1;
                mem_write_data <= sel_wdata;
              end else begin
                state    <= ST_RD;
                mem_read <= 1'b1;
              end
            end
          end
        end
        LOAD: begin
          state       <= RESP;
          mem_read    <= 1'b0;
          mem_address <= '0;
          rsp_valid   <= 1'b1;
          rsp_id      <= lat_id;
          rsp_rdata   <= load_ext(mem_read_data, lat_off, lat_size, lat_uns);
          rsp_err     <= 1'b0;
        end
        ST_RD: begin
          state          <= ST_WR;
          mem_read       <= 1'b0;
          mem_write      <= 1'b1;
          mem_write_data <= st_merge(mem_read_data, lat_wdata, lat_off, lat_size);
        end
        ST_WR: begin
          state          <= RESP;
          mem_write      <= 1'b0;
          mem_write_data <= 64'd0;
          mem_address    <= '0;
          rsp_valid      <= 1'b1;
          rsp_id         <= lat_id;
          rsp_rdata      <= 64'd0;
          rsp_err        <= 1'b0;
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_id    <= 1'b0;
          rsp_rdata <= 64'd0;
          rsp_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// Scoreboard bench for dmem_access_ctrl; a fixed-priority twin shares the request
// inputs and memory image so both arbitration modes are observed in one run.
module tb_dmem_access_ctrl;
  typedef struct packed {
    logic [31:0] cyc;
    logic        id;
    logic [63:0] rdata;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic m0_valid, m0_we, m0_unsigned, m1_valid, m1_we, m1_unsigned;
  logic [1:0] m0_size, m1_size;
  logic [63:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic m0_ready, m1_ready, rsp_valid, rsp_id, rsp_err, mem_read, mem_write;
  logic [63:0] rsp_rdata, mem_address, mem_write_data, mem_read_data;
  logic fp_m0_ready, fp_m1_ready, fp_rsp_valid, fp_rsp_id, fp_rsp_err, fp_mem_read, fp_mem_write;
  logic [63:0] fp_rsp_rdata, fp_mem_address, fp_mem_write_data, fp_mem_read_data;

  logic [63:0] mem_arr [0:255];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [63:0] pre_data;

  int   cyc = 0;
  int   wr_cnt = 0, act_cnt = 0, overlap_cnt = 0;
  int   checks = 0, passed = 0;
  rsp_t exp_q[$];
  rsp_t obs_q[$];

  dmem_access_ctrl #(.ADDR_W(64), .RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we), .m0_size(m0_size),
    .m0_unsigned(m0_unsigned), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we), .m1_size(m1_size),
    .m1_unsigned(m1_unsigned), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  dmem_access_ctrl #(.ADDR_W(64), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(m0_valid), .m0_ready(fp_m0_ready), .m0_we(m0_we), .m0_size(m0_size),
    .m0_unsigned(m0_unsigned), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_valid(m1_valid), .m1_ready(fp_m1_ready), .m1_we(m1_we), .m1_size(m1_size),
    .m1_unsigned(m1_unsigned), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .rsp_valid(fp_rsp_valid), .rsp_id(fp_rsp_id), .rsp_rdata(fp_rsp_rdata), .rsp_err(fp_rsp_err),
    .mem_read(fp_mem_read), .mem_write(fp_mem_write), .mem_address(fp_mem_address),
    .mem_write_data(fp_mem_write_data), .mem_read_data(fp_mem_read_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_read_data    = mem_arr[mem_address[10:3]];
  assign fp_mem_read_data = mem_arr[fp_mem_address[10:3]];
  always @(posedge clk) begin
    if (pre_we)         mem_arr[pre_idx] <= pre_data;
    else if (mem_write) mem_arr[mem_address[10:3]] <= mem_write_data;
  end

  always @(negedge clk) begin
    if (rsp_valid) obs_q.push_back({cyc, rsp_id, rsp_rdata, rsp_err});
    if (mem_write) wr_cnt <= wr_cnt + 1;
    if (mem_read || mem_write) act_cnt <= act_cnt + 1;
    if (mem_read && mem_write) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic preload(input logic [63:0] a, input logic [63:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = a[10:3]; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic drive_req(input logic p, input logic we, input logic [1:0] sz, input logic uns,
                           input logic [63:0] addr, input logic [63:0] wd, output int t_acc);
    t_acc = -1;
    @(negedge clk);
    if (!p) begin
      m0_valid = 1'b1; m0_we = we; m0_size = sz; m0_unsigned = uns; m0_addr = addr; m0_wdata = wd;
    end else begin
      m1_valid = 1'b1; m1_we = we; m1_size = sz; m1_unsigned = uns; m1_addr = addr; m1_wdata = wd;
    end
    for (int n = 0; n < 20; n++) begin
      #1;
      if ((!p && m0_ready) || (p && m1_ready)) begin t_acc = cyc; break; end
      @(negedge clk);
    end
    @(posedge clk); #1;
    // scramble the fields so a design that keeps sampling them after acceptance is exposed
    if (!p) begin
      m0_valid = 1'b0; m0_we = ~we; m0_size = ~sz; m0_unsigned = ~uns;
      m0_addr = {$urandom, $urandom}; m0_wdata = {$urandom, $urandom};
    end else begin
      m1_valid = 1'b0; m1_we = ~we; m1_size = ~sz; m1_unsigned = ~uns;
      m1_addr = {$urandom, $urandom}; m1_wdata = {$urandom, $urandom};
    end
  endtask

  task automatic wait_rsp(output rsp_t o);
    o = '0;
    o.cyc = '1;
    for (int n = 0; n < 12; n++) begin
      if (obs_q.size() > 0) begin o = obs_q.pop_front(); return; end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    preload(64'h100, 64'h1122334455667788);
    m0_valid = 1'b1; m0_we = 1'b0; m0_size = 2'd3; m0_addr = 64'h100;
    #1;
    checks++;
    if ({m0_ready, m1_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, mem_read, mem_write,
         mem_address, mem_write_data} !== '0)
      $display("FAIL reset_outputs: ready=%b%b rsp_valid=%b mem_rd=%b mem_wr=%b addr=%h wdata=%h, want all 0",
               m0_ready, m1_ready, rsp_valid, mem_read, mem_write, mem_address, mem_write_data);
    else passed++;
    m0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_store();
    int t, wr0;
    rsp_t o, e;
    drive_req(1'b1, 1'b1, 2'd1, 1'b0, 64'h102, 64'hABCD, t);
    @(negedge clk); #1;
    checks++;
    if (mem_read !== 1'b1 || cyc != t + 1)
      $display("FAIL mid_store_st_rd: mem_read=%b cyc=%0d, want 1 at %0d", mem_read, cyc, t + 1);
    else passed++;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({m0_ready, m1_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err, mem_read, mem_write,
         mem_address, mem_write_data} !== '0)
      $display("FAIL mid_store_reset_outputs: mem_rd=%b mem_wr=%b addr=%h, want all 0",
               mem_read, mem_write, mem_address);
    else passed++;
    wr0 = wr_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_cnt != wr0 || mem_arr[8'h20] !== 64'h1122334455667788)
      $display("FAIL mid_store_no_write: writes=%0d word=%h, want %0d and 1122334455667788",
               wr_cnt, mem_arr[8'h20], wr0);
    else passed++;
    @(negedge clk);
    m0_valid = 1'b1; m0_we = 1'b0; m0_size = 2'd3; m0_unsigned = 1'b0; m0_addr = 64'h100;
    m1_valid = 1'b1; m1_we = 1'b0; m1_size = 2'd3; m1_unsigned = 1'b0; m1_addr = 64'h100;
    #1;
    t = cyc;
    checks++;
    if ({m0_ready, m1_ready} !== 2'b10)
      $display("FAIL first_tie_grant: ready m0/m1=%b%b, want 10", m0_ready, m1_ready);
    else passed++;
    exp_q.push_back({t + 2, 1'b0, 64'h1122334455667788, 1'b0});
    @(posedge clk); #1;
    m0_valid = 1'b0; m1_valid = 1'b0;
    wait_rsp(o); e = exp_q.pop_front();
    checks++;
    if (o !== e)
      $display("FAIL rsp_first_tie: got cyc=%0d id=%0d rdata=%h err=%0d, want cyc=%0d id=%0d rdata=%h err=%0d",
               o.cyc, o.id, o.rdata, o.err, e.cyc, e.id, e.rdata, e.err);
    else passed++;
  endtask

  task automatic test_load();
    int t;
    rsp_t o, e;
    logic [1:0]  szs  [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
    logic        unss [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [63:0] adrs [8] = '{64'h107, 64'h107, 64'h101, 64'h106, 64'h100, 64'h104, 64'h100, 64'h100};
    logic [63:0] exps [8] = '{64'hFFFFFFFFFFFFFF88, 64'h0000000000000088, 64'h0000000000000077,
                              64'hFFFFFFFFFFFF8822, 64'h0000000000007788, 64'hFFFFFFFF88223344,
                              64'h0000000055667788, 64'h8822334455667788};
    preload(64'h100, 64'h1122334455667788);
    drive_req(1'b0, 1'b0, 2'd0, 1'b0, 64'h107, 64'h0, t);
    exp_q.push_back({t + 2, 1'b0, 64'h11, 1'b0});
    @(negedge clk); #1;
    checks++;
    if ({mem_read, mem_write, mem_address} !== {1'b1, 1'b0, 64'h100})
      $display("FAIL load_mem_cycle: rd=%b wr=%b addr=%h, want 1 0 100", mem_read, mem_write, mem_address);
    else passed++;
    wait_rsp(o); e = exp_q.pop_front();
    checks++;
    if (o !== e)
      $display("FAIL rsp_load_byte: got cyc=%0d id=%0d rdata=%h err=%0d, want cyc=%0d id=%0d rdata=%h err=%0d",
               o.cyc, o.id, o.rdata, o.err, e.cyc, e.id, e.rdata, e.err);
    else passed++;
    preload(64'h100, 64'h8822334455667788);
    for (int i = 0; i < 8; i++) begin
      drive_req(i[0], 1'b0, szs[i], unss[i], adrs[i], 64'h0, t);
      exp_q.push_back({t + 2, i[0], exps[i], 1'b0});
      wait_rsp(o); e = exp_q.pop_front();
      checks++;
      if (o !== e)
        $display("FAIL rsp_load_%0d: got cyc=%0d id=%0d rdata=%h err=%0d, want cyc=%0d id=%0d rdata=%h err=%0d",
                 i, o.cyc, o.id, o.rdata, o.err, e.cyc, e.id, e.rdata, e.err);
      else passed++;
    end
  endtask

  task automatic test_store_rmw();
    int t;
    rsp_t o, e;
    preload(64'h100, 64'h1122334455667788);
    drive_req(1'b1, 1'b1, 2'd1, 1'b0, 64'h102, 64'hFFFF00001234ABCD, t);
    exp_q.push_back({t + 3, 1'b1, 64'h0, 1'b0});
    @(negedge clk); #1;
    checks++;
    if ({mem_read, mem_write, mem_address} !== {1'b1, 1'b0, 64'h100})
      $display("FAIL rmw_read_cycle: rd=%b wr=%b addr=%h, want 1 0 100", mem_read, mem_write, mem_address);
    else passed++;
    @(negedge clk); #1;
    checks++;
    if ({mem_read, mem_write, mem_address, mem_write_data} !== {1'b0, 1'b1, 64'h100, 64'h11223344ABCD7788})
      $display("FAIL rmw_write_cycle: rd=%b wr=%b addr=%h data=%h, want 0 1 100 11223344abcd7788",
               mem_read, mem_write, mem_address, mem_write_data);
    else passed++;
    drive_req(1'b0, 1'b1, 2'd0, 1'b0, 64'h105, 64'h775A, t);
    exp_q.push_back({t + 3, 1'b0, 64'h0, 1'b0});
    drive_req(1'b0, 1'b0, 2'd3, 1'b0, 64'h100, 64'h0, t);
    exp_q.push_back({t + 2, 1'b0, 64'h11225A44ABCD7788, 1'b0});
    for (int i = 0; i < 3; i++) begin
      wait_rsp(o); e = exp_q.pop_front();
      checks++;
      if (o !== e)
        $display("FAIL rsp_rmw_%0d: got cyc=%0d id=%0d rdata=%h err=%0d, want cyc=%0d id=%0d rdata=%h err=%0d",
                 i, o.cyc, o.id, o.rdata, o.err, e.cyc, e.id, e.rdata, e.err);
      else passed++;
    end
  endtask

  task automatic test_misaligned();
    int t, a0;
    rsp_t o, e;
    logic        ps   [3] = '{1'b0, 1'b1, 1'b0};
    logic        wes  [3] = '{1'b0, 1'b1, 1'b1};
    logic [1:0]  szs  [3] = '{2'd2, 2'd3, 2'd1};
    logic [63:0] adrs [3] = '{64'h102, 64'h204, 64'h101};
    repeat (2) @(negedge clk);
    a0 = act_cnt;
    for (int i = 0; i < 3; i++) begin
      drive_req(ps[i], wes[i], szs[i], 1'b0, adrs[i], 64'h55, t);
      exp_q.push_back({t + 1, ps[i], 64'h0, 1'b1});
      wait_rsp(o); e = exp_q.pop_front();
      checks++;
      if (o !== e)
        $display("FAIL rsp_misaligned_%0d: got cyc=%0d id=%0d rdata=%h err=%0d, want cyc=%0d id=%0d rdata=%h err=%0d",
                 i, o.cyc, o.id, o.rdata, o.err, e.cyc, e.id, e.rdata, e.err);
      else passed++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (act_cnt != a0)
      $display("FAIL misaligned_no_mem: memory active cycles=%0d, want 0", act_cnt - a0);
    else passed++;
  endtask

  task automatic test_arbitration();
    int t, g_rr, g_fp;
    rsp_t o, e;
    logic rr [4];
    logic fp [4];
    logic fp_m1_seen;
    g_rr = 0; g_fp = 0; fp_m1_seen = 1'b0;
    rr = '{1'bx, 1'bx, 1'bx, 1'bx};
    fp = '{1'bx, 1'bx, 1'bx, 1'bx};
    preload(64'h100, 64'h0A0A0A0A0A0A0A0A);
    preload(64'h200, 64'h0B0B0B0B0B0B0B0B);
    drive_req(1'b1, 1'b0, 2'd3, 1'b0, 64'h200, 64'h0, t);
    exp_q.push_back({t + 2, 1'b1, 64'h0B0B0B0B0B0B0B0B, 1'b0});
    wait_rsp(o); e = exp_q.pop_front();
    checks++;
    if (o !== e)
      $display("FAIL rsp_arb_prime: got cyc=%0d id=%0d rdata=%h err=%0d, want cyc=%0d id=%0d rdata=%h err=%0d",
               o.cyc, o.id, o.rdata, o.err, e.cyc, e.id, e.rdata, e.err);
    else passed++;
    @(negedge clk);
    m0_valid = 1'b1; m0_we = 1'b0; m0_size = 2'd3; m0_unsigned = 1'b0; m0_addr = 64'h100;
    m1_valid = 1'b1; m1_we = 1'b0; m1_size = 2'd3; m1_unsigned = 1'b0; m1_addr = 64'h200;
    for (int n = 0; n < 40; n++) begin
      #1;
      if ((m0_ready || m1_ready) && g_rr < 4) begin
        rr[g_rr] = m1_ready;
        exp_q.push_back({cyc + 2, m1_ready, m1_ready ? 64'h0B0B0B0B0B0B0B0B : 64'h0A0A0A0A0A0A0A0A, 1'b0});
        g_rr++;
      end
      if ((fp_m0_ready || fp_m1_ready) && g_fp < 4) begin
        fp[g_fp] = fp_m1_ready;
        g_fp++;
      end
      if (fp_m1_ready) fp_m1_seen = 1'b1;
      @(negedge clk);
      if (g_rr >= 4 && g_fp >= 4) break;
    end
    m0_valid = 1'b0; m1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rr[i] !== i[0]) $display("FAIL rr_grant_%0d: got %b, want %b", i, rr[i], i[0]);
      else passed++;
      checks++;
      if (fp[i] !== 1'b0) $display("FAIL fp_grant_%0d: got %b, want 0", i, fp[i]);
      else passed++;
    end
    checks++;
    if (fp_m1_seen !== 1'b0) $display("FAIL fp_m1_ready: got %b, want 0", fp_m1_seen);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      wait_rsp(o); e = exp_q.pop_front();
      checks++;
      if (o !== e)
        $display("FAIL rsp_arb_%0d: got cyc=%0d id=%0d rdata=%h err=%0d, want cyc=%0d id=%0d rdata=%h err=%0d",
                 i, o.cyc, o.id, o.rdata, o.err, e.cyc, e.id, e.rdata, e.err);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int t1, t2, t3;
    rsp_t o, e;
    drive_req(1'b0, 1'b1, 2'd3, 1'b0, 64'h200, 64'hDEADBEEFCAFEF00D, t1);
    exp_q.push_back({t1 + 2, 1'b0, 64'h0, 1'b0});
    #1;
    checks++;
    if ({mem_read, mem_write, mem_address, mem_write_data} !== {1'b0, 1'b1, 64'h200, 64'hDEADBEEFCAFEF00D})
      $display("FAIL full_store_write: rd=%b wr=%b addr=%h data=%h, want 0 1 200 deadbeefcafef00d",
               mem_read, mem_write, mem_address, mem_write_data);
    else passed++;
    drive_req(1'b0, 1'b0, 2'd2, 1'b1, 64'h204, 64'h0, t2);
    exp_q.push_back({t2 + 2, 1'b0, 64'h00000000DEADBEEF, 1'b0});
    checks++;
    if (t2 != t1 + 3) $display("FAIL b2b_accept: got cycle %0d, want %0d", t2, t1 + 3);
    else passed++;
    drive_req(1'b1, 1'b0, 2'd2, 1'b0, 64'h204, 64'h0, t3);
    exp_q.push_back({t3 + 2, 1'b1, 64'hFFFFFFFFDEADBEEF, 1'b0});
    for (int i = 0; i < 3; i++) begin
      wait_rsp(o); e = exp_q.pop_front();
      checks++;
      if (o !== e)
        $display("FAIL rsp_b2b_%0d: got cyc=%0d id=%0d rdata=%h err=%0d, want cyc=%0d id=%0d rdata=%h err=%0d",
                 i, o.cyc, o.id, o.rdata, o.err, e.cyc, e.id, e.rdata, e.err);
      else passed++;
    end
  endtask

  task automatic test_end();
    repeat (4) @(negedge clk);
    checks++;
    if (obs_q.size() != 0 || exp_q.size() != 0)
      $display("FAIL leftover_rsp: observed=%0d expected=%0d, want 0 0", obs_q.size(), exp_q.size());
    else passed++;
    checks++;
    if (overlap_cnt != 0) $display("FAIL rd_wr_overlap: got %0d cycles, want 0", overlap_cnt);
    else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_valid = 1'b0; m0_we = 1'b0; m0_size = 2'd0; m0_unsigned = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_valid = 1'b0; m1_we = 1'b0; m1_size = 2'd0; m1_unsigned = 1'b0; m1_addr = '0; m1_wdata = '0;
    pre_we = 1'b0; pre_idx = '0; pre_data = '0;
    test_reset();
    test_reset_mid_store();
    test_load();
    test_store_rmw();
    test_misaligned();
    test_arbitration();
    test_back_to_back();
    test_end();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
